cache_dram_bridge: RTL and testbench

Protocol bridge between the L1 cache's memory-side port and the master FIFO toward DRAM. It converts the cache's level-held request (`mem_req`, valid until acknowledged) into a single-cycle FIFO request pulse, waits for the DRAM read response, and returns it to the cache as a one-cycle `mem_data.ready` pulse. A read watchdog and sticky error flags make DRAM-side hangs observable on the board.

---
 rtl/cache_dram_bridge_pkg.sv | 40 ++++
 rtl/cache_dram_bridge_if.sv | 22 ++
 rtl/bridge_watchdog.sv | 30 +++
 rtl/cache_dram_bridge.sv | 114 +++++++++++
 tb/tb_cache_dram_bridge.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_dram_bridge_pkg.sv
// Shared types and constants for the L1 cache <-> DRAM master FIFO bridge.
// L1_cache imports this package as well.
package cache_dram_bridge_pkg;

  localparam int unsigned L2_ADDR_W = 27;
  localparam int unsigned L2_LINE_W = 128;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

  typedef struct packed {
    logic [L2_ADDR_W-1:0] addr;
    logic [L2_LINE_W-1:0] data;
    logic                 rw;     // 1 = write, 0 = read
    logic                 valid;
  } L2_req_type;

  typedef struct packed {
    logic [L2_LINE_W-1:0] data;
    logic                 ready;
  } mem_data_type;

  typedef struct packed {
    logic                 cmd;
    logic [L2_ADDR_W-1:0] addr;
    logic [L2_LINE_W-1:0] data;
  } fifo_req_t;

  typedef struct packed {
    logic [L2_LINE_W-1:0] data;
  } fifo_rsp_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRsp,
    StDone
  } bridge_state_e;

endpackage

// File: rtl/cache_dram_bridge_if.sv
// Request/response handshake toward the DRAM master FIFO.
interface cache_dram_bridge_if;
  import cache_dram_bridge_pkg::*;

  fifo_req_t req;
  logic      req_en;
  logic      req_rdy;
  fifo_rsp_t rsp;
  logic      rsp_en;
  logic      rsp_rdy;

  modport master (
    output req, req_en, rsp_rdy,
    input  req_rdy, rsp, rsp_en
  );

  modport slave (
    input  req, req_en, rsp_rdy,
    output req_rdy, rsp, rsp_en
  );

endinterface

// File: rtl/bridge_watchdog.sv
// Read watchdog: counts enabled cycles from a clear, flags the last allowed cycle.
// TIMEOUT = 0 disables it.
module bridge_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] Limit = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && en && (cnt_q == Limit);

endmodule

// File: rtl/cache_dram_bridge.sv
// Turns the cache's level-held request into one FIFO request pulse and returns
// the DRAM read data as a one-cycle ready pulse; sticky flags expose DRAM hangs.
module cache_dram_bridge
  import cache_dram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = L2_ADDR_W,  // must match the package widths
  parameter int unsigned LINE_W  = L2_LINE_W,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  L2_req_type                 mem_req,
  output mem_data_type               mem_data,
  cache_dram_bridge_if.master        master_fifo,
  output logic                       err_timeout,
  output logic                       err_spurious
);

  bridge_state_e     state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] data_q;
  logic              cmd_q;
  logic [LINE_W-1:0] rsp_q;
  logic              ready_q;
  logic              err_timeout_q;
  logic              err_spurious_q;

  logic req_en;
  logic wd_expired;

  assign req_en = (state_q == StIssue) && master_fifo.req_rdy;

  bridge_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clr     (state_q == StIssue),
    .en      (state_q == StWaitRsp),
    .expired (wd_expired)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      data_q         <= '0;
      cmd_q          <= 1'b0;
      rsp_q          <= '0;
      ready_q        <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      // Responses are only expected while a read is outstanding.
      if (master_fifo.rsp_en && (state_q != StWaitRsp)) begin
        err_spurious_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (mem_req.valid) begin
            addr_q  <= mem_req.addr;
            data_q  <= mem_req.rw ? mem_req.data : '0;
            cmd_q   <= mem_req.rw ? CMD_WRITE : CMD_READ;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (req_en) begin
            if (cmd_q == CMD_WRITE) begin
              rsp_q   <= '0;
              ready_q <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StWaitRsp;
            end
          end
        end
        StWaitRsp: begin
          // A response arriving on the expiry cycle takes priority.
          if (master_fifo.rsp_en) begin
            rsp_q   <= master_fifo.rsp.data;
            ready_q <= 1'b1;
            state_q <= StDone;
          end else if (wd_expired) begin
            err_timeout_q <= 1'b1;
            rsp_q         <= '0;
            ready_q       <= 1'b1;
            state_q       <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign master_fifo.req.cmd  = cmd_q;
  assign master_fifo.req.addr = addr_q;
  assign master_fifo.req.data = data_q;
  assign master_fifo.req_en   = req_en;
  assign master_fifo.rsp_rdy  = 1'b1;

  assign mem_data.data  = rsp_q;
  assign mem_data.ready = ready_q;

  assign err_timeout  = err_timeout_q;
  assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_cache_dram_bridge.sv
// Bench for cache_dram_bridge: table-driven transactions, scoreboard on the FIFO
// request and cache response sides, plus reset/timeout/back-to-back sequences.
module tb_cache_dram_bridge;
  import cache_dram_bridge_pkg::*;

  logic         sys_clk;
  logic         rst_n;
  L2_req_type   mem_req;
  mem_data_type mem_data;
  logic         err_timeout;
  logic         err_spurious;

  cache_dram_bridge_if fifo_if ();

  cache_dram_bridge #(
    .ADDR_W  (27),
    .LINE_W  (128),
    .TIMEOUT (8)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .mem_data     (mem_data),
    .master_fifo  (fifo_if),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic         rw;
    logic [26:0]  addr;
    logic [127:0] wdata;
    int           rdy_low;    // ISSUE cycles with fifo_req_rdy low
    int           delay;      // cycles from fifo_req_en to fifo_rsp_en, -1 = never
    logic [127:0] rdata;
    logic         exp_cmd;
    logic [127:0] exp_fdata;
    logic [127:0] exp_rdata;
    int           exp_lat;    // ready cycle counted from the accept cycle
    logic         exp_tmo;
    logic         exp_spur;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  int en_total  = 0;
  int rdy_total = 0;

  logic [155:0] exp_req_q[$];
  logic [127:0] exp_rsp_q[$];
  logic [127:0] dram [logic [26:0]];
  logic [155:0] mon_req;
  logic [127:0] mon_rsp;

  localparam logic [26:0]  AddrA = 27'h2aaaaaa;
  localparam logic [127:0] WrData = 128'h33333333_33333333_33333333_33333333;
  localparam logic [127:0] RdData = 128'h1c71c71c_33333333_00000000_00000000;
  localparam logic [127:0] Junk   = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [26:0] a, input logic [127:0] wd,
                              input int rl, input int dl, input logic [127:0] rd,
                              input logic [127:0] exp_r, input int lat, input logic tmo,
                              input logic spur);
    vec_t v;
    v.rw = rw; v.addr = a; v.wdata = wd; v.rdy_low = rl; v.delay = dl; v.rdata = rd;
    v.exp_cmd = ~rw; v.exp_fdata = rw ? wd : 128'h0; v.exp_rdata = exp_r;
    v.exp_lat = lat; v.exp_tmo = tmo; v.exp_spur = spur;
    return v;
  endfunction

  // Scoreboard: compare every request pulse and every ready pulse in order.
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (fifo_if.req_en) begin
        en_total++;
        if (!fifo_if.req.cmd) dram[fifo_if.req.addr] = fifo_if.req.data;
        if (exp_req_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_req: got pulse addr %0h expected none", fifo_if.req.addr);
        end else begin
          mon_req = exp_req_q.pop_front();
          check("fifo_req", 160'({fifo_if.req.cmd, fifo_if.req.addr, fifo_if.req.data}),
                160'(mon_req));
        end
      end
      if (mem_data.ready) begin
        rdy_total++;
        if (exp_rsp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_ready: got data %0h expected no pulse", mem_data.data);
        end else begin
          mon_rsp = exp_rsp_q.pop_front();
          check("ready_data", 160'(mem_data.data), 160'(mon_rsp));
        end
      end
    end
  end

  // One full transaction; entered at or after a negedge, leaves at the ready negedge.
  task automatic do_txn(input vec_t v, input bit use_mem);
    int en_cyc  = -1;
    int rdy_cyc = -1;
    int n_en    = 0;
    logic [127:0] rsp_val;
    exp_req_q.push_back({v.exp_cmd, v.addr, v.exp_fdata});
    exp_rsp_q.push_back(v.exp_rdata);
    @(posedge sys_clk); #1;
    mem_req = '{addr: v.addr, data: v.wdata, rw: v.rw, valid: 1'b1};
    for (int c = 0; c < 40; c++) begin
      rsp_val = (use_mem && dram.exists(v.addr)) ? dram[v.addr] : v.rdata;
      fifo_if.req_rdy  = (c >= 1 + v.rdy_low);
      fifo_if.rsp_en   = (en_cyc >= 0) && (v.delay >= 0) && (c == en_cyc + v.delay);
      fifo_if.rsp.data = fifo_if.rsp_en ? rsp_val : Junk;
      @(negedge sys_clk);
      if (fifo_if.req_en) begin
        n_en++;
        if (en_cyc < 0) en_cyc = c;
      end
      if (mem_data.ready) begin
        rdy_cyc = c;
        break;
      end
      @(posedge sys_clk); #1;
    end
    mem_req.valid  = 1'b0;
    fifo_if.rsp_en = 1'b0;
    check("ready_latency", 160'(rdy_cyc), 160'(v.exp_lat));
    check("req_en_count", 160'(n_en), 160'(1));
    check("err_timeout", 160'(err_timeout), 160'(v.exp_tmo));
    check("err_spurious", 160'(err_spurious), 160'(v.exp_spur));
  endtask

  task automatic pulse_rsp();
    @(posedge sys_clk); #1;
    fifo_if.rsp_en   = 1'b1;
    fifo_if.rsp.data = Junk;
    @(posedge sys_clk); #1;
    fifo_if.rsp_en   = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_en"}, 160'(fifo_if.req_en), 160'(0));
    check({tag, "_ready"}, 160'(mem_data.ready), 160'(0));
    check({tag, "_req_fields"}, 160'({fifo_if.req.cmd, fifo_if.req.addr, fifo_if.req.data}),
          160'(0));
    check({tag, "_rsp_data"}, 160'(mem_data.data), 160'(0));
    check({tag, "_errs"}, 160'({err_timeout, err_spurious}), 160'(0));
    check({tag, "_rsp_rdy"}, 160'(fifo_if.rsp_rdy), 160'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL bench_time_limit: got no finish expected finish before 200000");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    logic [127:0] wd;
    logic [26:0]  ad;
    int en0, rdy0, dl;
    bit found;

    vecs[0] = mk(1'b1, AddrA, WrData, 0, -1, 128'h0, 128'h0, 2, 1'b0, 1'b0);   // write
    vecs[1] = mk(1'b0, AddrA, WrData, 0, 5, RdData, RdData, 7, 1'b0, 1'b0);     // read
    vecs[2] = mk(1'b1, 27'h0000123, 128'h5, 4, -1, 128'h0, 128'h0, 6, 1'b0, 1'b0);
    vecs[3] = mk(1'b0, 27'h7ffffff, 128'h0, 2, 3, 128'hab, 128'hab, 7, 1'b0, 1'b0);
    vecs[4] = mk(1'b0, 27'h0000001, 128'h0, 0, 7, ~RdData, ~RdData, 9, 1'b0, 1'b0);
    vecs[5] = mk(1'b0, 27'h0000002, 128'h0, 0, 8, 128'h77, 128'h77, 10, 1'b0, 1'b0);
    vecs[6] = mk(1'b0, 27'h0000003, 128'h0, 0, -1, 128'h99, 128'h0, 10, 1'b1, 1'b0);

    rst_n = 1'b0;
    mem_req = '0;
    fifo_if.req_rdy = 1'b0;
    fifo_if.rsp_en = 1'b0;
    fifo_if.rsp.data = '0;
    repeat (3) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    @(negedge sys_clk);
    check_reset_outputs("por");

    for (int i = 0; i < 7; i++) do_txn(vecs[i], 1'b0);

    // Late response after the timeout has already closed the read.
    pulse_rsp();
    check("late_rsp_spurious", 160'(err_spurious), 160'(1));
    check("late_rsp_timeout_kept", 160'(err_timeout), 160'(1));

    // Reset while a read is outstanding.
    exp_req_q.push_back({1'b1, 27'h0000444, 128'h0});
    exp_rsp_q.push_back(128'h0);
    @(posedge sys_clk); #1;
    mem_req = '{addr: 27'h0000444, data: Junk, rw: 1'b0, valid: 1'b1};
    fifo_if.req_rdy = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      if (fifo_if.req_en) begin
        found = 1'b1;
        break;
      end
      @(posedge sys_clk); #1;
    end
    check("rst_seq_req_seen", 160'(found), 160'(1));
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    exp_rsp_q.delete();
    mem_req = '0;
    @(posedge sys_clk); #1 rst_n = 1'b1;
    pulse_rsp();
    check("post_rst_spurious", 160'(err_spurious), 160'(1));
    check("post_rst_timeout", 160'(err_timeout), 160'(0));
    do_txn(mk(1'b1, 27'h0000555, 128'hc0ffee, 0, -1, 128'h0, 128'h0, 2, 1'b0, 1'b1), 1'b0);

    // Back-to-back alternating write/read pairs.
    en0 = en_total;
    rdy0 = rdy_total;
    for (int i = 0; i < 16; i++) begin
      ad = i[0] ? 27'h0314aab : 27'h0314aaa;
      wd = {$urandom, $urandom, $urandom, $urandom};
      dl = 1 + (i % 4);
      v = mk(1'b1, ad, wd, 0, -1, 128'h0, 128'h0, 2, 1'b0, 1'b1);
      do_txn(v, 1'b0);
      v = mk(1'b0, ad, 128'h0, 0, dl, Junk, wd, dl + 2, 1'b0, 1'b1);
      do_txn(v, 1'b1);
    end
    check("b2b_req_pulses", 160'(en_total - en0), 160'(32));
    check("b2b_ready_pulses", 160'(rdy_total - rdy0), 160'(32));

    repeat (3) @(negedge sys_clk);
    check("sb_drain", 160'(exp_req_q.size() + exp_rsp_q.size()), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
